// File: rtl/mbc_run_sequencer.sv
// Run controller for the MBC core: reset/enable sequencing, HLT and watchdog detection,
// enabled-cycle counting and a valid/ready trace FIFO of {cu_data, ac_data} samples.
module mbc_run_sequencer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned MAX_CYCLES  = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  input  logic                halt_in,
  input  logic [DATA_W-1:0]   cu_data,
  input  logic [DATA_W-1:0]   ac_data,
  output logic                dut_reset,
  output logic                dut_en,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [2*DATA_W-1:0] trace_data,
  output logic                trace_overflow
);

  localparam int unsigned PtrW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StRst, StRun, StHalt, StTout} state_e;

  state_e              state_q, state_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                dut_reset_q, busy_q, done_q, timeout_q;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   last_ac_q;
  logic                ovf_q, ovf_d;

  logic [2*DATA_W-1:0] mem_q [TRACE_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q, count_d;
  logic                full, pop, push_req, push_ok;

  // Next-state and run-control logic
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRst;
          rst_cnt_d = '0;
        end
      end
      StRst: begin
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StRun: begin
        // HLT has priority over the watchdog when both fire on the same enabled cycle.
        if (en_q && halt_in) begin
          state_d = StHalt;
        end else if (en_q && (cnt_q == CNT_W'(MAX_CYCLES - 1))) begin
          state_d = StTout;
        end
      end
      StHalt, StTout: begin
        if (start) begin
          state_d   = StRst;
          rst_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    en_d = (state_d == StRun) && (!step_mode || step);

    if (state_d == StRst) begin
      cnt_d = '0;
    end else if (en_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (state_d == StRst) begin
      first_d = 1'b1;
    end else if (en_q) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end
  end

  // Trace capture and FIFO control
  always_comb begin
    full     = (count_q == (PtrW + 1)'(TRACE_DEPTH));
    pop      = trace_valid && trace_ready;
    push_req = en_q && (first_q || (ac_data != last_ac_q));
    push_ok  = push_req && (!full || pop);

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end

    ovf_d = ovf_q;
    if ((state_d == StRst) && (state_q != StRst)) begin
      ovf_d = 1'b0;
    end else if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      first_q     <= 1'b1;
      last_ac_q   <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      dut_reset_q <= (state_d == StIdle) || (state_d == StRst);
      busy_q      <= (state_d == StRst) || (state_d == StRun);
      done_q      <= (state_d == StHalt);
      timeout_q   <= (state_d == StTout);
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      if (push_ok) begin
        last_ac_q <= ac_data;
        wr_ptr_q  <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {cu_data, ac_data};
    end
  end

  assign dut_reset      = dut_reset_q;
  assign dut_en         = en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign cycle_cnt      = cnt_q;
  assign trace_overflow = ovf_q;
  assign trace_valid    = (count_q != '0);
  assign trace_data     = mem_q[rd_ptr_q];

endmodule
